// File: rtl/carregador_programa.sv
// Program loader: receives a LEN / data / CSUM byte frame over valid/ready,
// writes each 16-bit word to program memory and holds the processor in reset until the image verifies.
module carregador_programa #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              proc_reset,
    output logic              done,
    output logic [1:0]        err_code
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [16:0]       CAPACITY  = 17'd1 << ADDR_W;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE, ERR
    } state_t;

    state_t            state;
    logic [7:0]        hi_byte;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   index;
    logic [15:0]       sum;
    logic [IDLE_W-1:0] idle;
    logic              xfer;
    logic [15:0]       word;

    assign xfer = in_valid & in_ready;
    assign word = {hi_byte, in_data};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= LEN_HI;
            hi_byte    <= '0;
            len        <= '0;
            index      <= '0;
            sum        <= '0;
            idle       <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            proc_reset <= 1'b1;
            done       <= 1'b0;
            err_code   <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                DONE, ERR: begin
                    if (load) begin
                        state      <= LEN_HI;
                        len        <= '0;
                        index      <= '0;
                        sum        <= '0;
                        idle       <= '0;
                        in_ready   <= 1'b1;
                        proc_reset <= 1'b1;
                        done       <= 1'b0;
                        err_code   <= '0;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        idle <= '0;
                        case (state)
                            LEN_HI: begin
                                hi_byte <= in_data;
                                state   <= LEN_LO;
                            end
                            LEN_LO: begin
                                if ({1'b0, word} > CAPACITY) begin
                                    state    <= ERR;
                                    err_code <= 2'd1;
                                    in_ready <= 1'b0;
                                end else begin
                                    len   <= word[ADDR_W:0];
                                    index <= '0;
                                    sum   <= '0;
                                    state <= (word == 16'h0000) ? CSUM_HI : DATA_HI;
                                end
                            end
                            DATA_HI: begin
                                hi_byte <= in_data;
                                state   <= DATA_LO;
                            end
                            DATA_LO: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= index[ADDR_W-1:0];
                                mem_wdata <= word;
                                sum       <= sum + word;
                                index     <= index + 1'b1;
                                state     <= (index == len - 1'b1) ? CSUM_HI : DATA_HI;
                            end
                            CSUM_HI: begin
                                hi_byte <= in_data;
                                state   <= CSUM_LO;
                            end
                            CSUM_LO: begin
                                in_ready <= 1'b0;
                                if (word == sum) begin
                                    state      <= DONE;
                                    done       <= 1'b1;
                                    proc_reset <= 1'b0;
                                end else begin
                                    state    <= ERR;
                                    err_code <= 2'd2;
                                end
                            end
                            default: ;
                        endcase
                    end else if (state != LEN_HI) begin
                        // Idle time only counts once a frame has started.
                        if (idle == IDLE_LAST) begin
                            state    <= ERR;
                            err_code <= 2'd3;
                            in_ready <= 1'b0;
                        end else begin
                            idle <= idle + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Scoreboard bench for carregador_programa: a frame-level reference model predicts
// memory writes and final status; a monitor checks every write strobe against the queue.
module tb_carregador_programa;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 1023;

    logic              clock = 1'b0;
    logic              reset, load, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, mem_we, proc_reset, done;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        err_code;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame[$];
    logic [23:0] sb[$];

    carregador_programa #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .load(load), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .proc_reset(proc_reset), .done(done), .err_code(err_code)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%04h, required no write", mem_addr, mem_wdata);
            end else begin
                logic [23:0] exp;
                exp = sb.pop_front();
                if ({mem_addr, mem_wdata} !== exp) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%04h, required addr=%0h data=%04h",
                             mem_addr, mem_wdata, exp[23:16], exp[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic pulse_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got in_ready=0 for %0d cycles, required 1", w);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int nsent, input int maxgap);
        for (int i = 0; i < nsent; i++)
            send_byte(frame[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    // Frame-level reference: -1 incomplete, 0 loaded, 1 length overflow, 2 checksum mismatch.
    task automatic model(input int nsent, output int res);
        int n;
        logic [15:0] s, w;
        res = -1;
        if (nsent < 2) return;
        n = int'({frame[0], frame[1]});
        if (n > (1 << ADDR_W)) begin
            res = 1;
            return;
        end
        s = 16'h0000;
        for (int i = 0; i < n; i++) begin
            if (nsent < 4 + 2 * i) return;
            w = {frame[2 + 2 * i], frame[3 + 2 * i]};
            sb.push_back({8'(i), w});
            s = s + w;
        end
        if (nsent < 4 + 2 * n) return;
        res = ({frame[2 + 2 * n], frame[3 + 2 * n]} == s) ? 0 : 2;
    endtask

    task automatic build_frame(input int n, input bit good);
        logic [15:0] s, w;
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        s = 16'h0000;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            frame.push_back(w[15:8]);
            frame.push_back(w[7:0]);
            s = s + w;
        end
        if (!good) s = s + 16'($urandom_range(1, 100));
        frame.push_back(s[15:8]);
        frame.push_back(s[7:0]);
    endtask

    task automatic set_frame2();
        frame = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'hBE, 8'h02};
    endtask

    task automatic check_result(input string tag, input int res);
        check({tag, "_done"}, int'(done), (res == 0) ? 1 : 0);
        check({tag, "_proc_reset"}, int'(proc_reset), (res == 0) ? 0 : 1);
        check({tag, "_err_code"}, int'(err_code), (res < 0) ? 0 : ((res == 0) ? 0 : res));
        check({tag, "_in_ready"}, int'(in_ready), (res < 0) ? 1 : 0);
        check({tag, "_pending_writes"}, sb.size(), 0);
    endtask

    initial begin
        int res;
        reset = 1'b0; load = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_mem_addr", int'(mem_addr), 0);
        check("reset_mem_wdata", int'(mem_wdata), 0);
        reset = 1'b1;
        tick();

        // 1: idle after reset
        repeat (20) tick();
        check_result("idle", -1);

        // 2: reference frame
        set_frame2();
        model(frame.size(), res);
        check("frame2_model", res, 0);
        send_frame(frame.size(), 0);
        check_result("frame2", res);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (5) tick();
        in_valid = 1'b0;
        check_result("frame2_ignored", 0);

        // 3: bad checksum
        do_reset();
        set_frame2();
        frame[8] = 8'h00; frame[9] = 8'h00;
        model(frame.size(), res);
        send_frame(frame.size(), 0);
        check_result("bad_csum", res);
        check("bad_csum_code", int'(err_code), 2);

        // 4: length overflow, error right after the 2nd byte
        do_reset();
        frame = '{8'h01, 8'h01};
        model(2, res);
        send_frame(2, 0);
        check_result("overflow", res);
        check("overflow_code", int'(err_code), 1);

        // 5: timeout, then reload
        do_reset();
        set_frame2();
        model(3, res);
        send_frame(3, 0);
        repeat (TIMEOUT - 1) tick();
        check("timeout_early", int'(err_code), 0);
        tick();
        check("timeout_code", int'(err_code), 3);
        repeat (5) tick();
        check_result("timeout_hold", 3);
        pulse_load();
        check_result("after_load", -1);
        frame = '{8'h00, 8'h01, 8'h00, 8'h07, 8'h00, 8'h07};
        model(frame.size(), res);
        send_frame(frame.size(), 0);
        check_result("reload", res);

        // 6: reset mid-frame after the 2nd word
        do_reset();
        set_frame2();
        model(6, res);
        send_frame(6, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_proc_reset", int'(proc_reset), 1);
        check("midreset_in_ready", int'(in_ready), 0);
        tick();
        repeat (5) tick();
        check_result("midreset_idle", -1);
        model(frame.size(), res);
        send_frame(frame.size(), 0);
        check_result("midreset_full", res);

        // 7: gapped reference frame, then random frames
        pulse_load();
        set_frame2();
        model(frame.size(), res);
        send_frame(frame.size(), 8);
        check_result("gapped", res);
        for (int k = 0; k < 14; k++) begin
            pulse_load();
            build_frame(int'($urandom_range(0, 6)), $urandom_range(0, 3) != 0);
            model(frame.size(), res);
            send_frame(frame.size(), 6);
            check_result("random", res);
        end

        // Full capacity frame: N == 2**ADDR_W is legal
        pulse_load();
        build_frame(1 << ADDR_W, 1'b1);
        model(frame.size(), res);
        send_frame(frame.size(), 0);
        check_result("full_capacity", res);

        repeat (4) tick();
        check("final_pending_writes", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
